ahb_lite_sram_slave: RTL and testbench



---
 rtl/ahb_lite_sram_slave.sv | 151 +++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: byte/half/word access, two-cycle ERROR response, read-after-write forwarding.
// Optional wait-state insertion is compiled in when AHB_SLAVE_WAIT_STATES_EN is defined.
module ahb_lite_sram_slave #(
    parameter int          MEM_BYTES   = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int AW        = $clog2(MEM_BYTES);
    localparam int MEM_WORDS = MEM_BYTES / 4;

    typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q;
    logic           write_q;
    logic [1:0]     size_q;
    logic [31:0]    mem [MEM_WORDS];

    logic           slave_ready, capture, illegal, wait_done;
    logic           rd_from_capture, rd_from_wait, wr_commit, fwd_hit;
    logic [AW-3:0]  rd_idx;
    logic [3:0]     wr_be;
    logic [31:0]    rd_word;
    logic           unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_mask = 4'b0001 << off;
            2'd1:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        for (int k = 0; k < 4; k++)
            merge_lanes[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    endfunction

`ifdef AHB_SLAVE_WAIT_STATES_EN
    localparam bit         WAIT_EN   = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
    logic [3:0] wait_cnt_q;

    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            wait_cnt_q <= 4'd0;
        else if (state_q == ST_WAIT)
            wait_cnt_q <= wait_cnt_q + 4'd1;
        else
            wait_cnt_q <= 4'd0;
    end

    assign wait_done = (wait_cnt_q == WAIT_LAST);
`else
    localparam bit WAIT_EN = 1'b0;
    localparam int unused_wait_cycles = WAIT_CYCLES;
    assign wait_done = 1'b1;
`endif

    // Capture is only possible while this slave is not stretching a data phase.
    assign slave_ready = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign capture     = HSEL && HREADY && HTRANS[1] && slave_ready;
    assign illegal     = (HSIZE > 3'd2)
                      || (HSIZE == 3'd1 && HADDR[0])
                      || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
                      || (HADDR[31:AW] != BASE_ADDR[31:AW]);

    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT: if (wait_done) state_d = ST_DATA;
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (!capture)
                    state_d = ST_IDLE;
                else if (illegal)
                    state_d = ST_ERR1;
                else if (WAIT_EN)
                    state_d = ST_WAIT;
                else
                    state_d = ST_DATA;
            end
        endcase
    end

    always_comb begin
        HREADYOUT = slave_ready;
        HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    end

    always_ff @(posedge HCLK) begin
        if (capture) begin
            addr_q  <= HADDR[AW-1:0];
            write_q <= HWRITE;
            size_q  <= HSIZE[1:0];
        end
    end

    // Read data is fetched on the edge that enters the read's final data cycle;
    // a write committing on that same edge to the same word is merged in.
    assign wr_commit       = (state_q == ST_DATA) && write_q;
    assign wr_be           = lane_mask(size_q, addr_q[1:0]);
    assign rd_from_capture = capture && !illegal && !HWRITE && !WAIT_EN;
    assign rd_from_wait    = (state_q == ST_WAIT) && wait_done && !write_q;
    assign rd_idx          = rd_from_capture ? HADDR[AW-1:2] : addr_q[AW-1:2];
    assign fwd_hit         = wr_commit && (addr_q[AW-1:2] == rd_idx);
    assign rd_word         = fwd_hit ? merge_lanes(mem[rd_idx], HWDATA, wr_be) : mem[rd_idx];

    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            HRDATA <= 32'd0;
        else if (rd_from_capture || rd_from_wait)
            HRDATA <= rd_word;
    end

    always_ff @(posedge HCLK) begin
        if (wr_commit && HRESETn) begin
            for (int k = 0; k < 4; k++)
                if (wr_be[k])
                    mem[addr_q[AW-1:2]][8*k +: 8] <= HWDATA[8*k +: 8];
        end
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomized bench for ahb_lite_sram_slave against a byte-array transaction model.
module tb_ahb_lite_sram_slave;

    localparam int          MEM_BYTES   = 4096;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
    localparam int          WAIT_CYCLES = 2;
`ifdef AHB_SLAVE_WAIT_STATES_EN
    localparam int EXP_WAITS = WAIT_CYCLES;
`else
    localparam int EXP_WAITS = 0;
`endif
    localparam int WIN = 64;

    logic        HCLK, HRESETn, HSEL, HWRITE, HMASTLOCK, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    ahb_lite_sram_slave #(
        .MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE_ADDR), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // kind: 0 = transfer, 1 = idle-ish cycle, 2 = stalled NONSEQ (HREADY low)
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        sel;
        logic [1:0]  trans;
        logic        chk;
        logic [31:0] cval;
    } xfer_t;

    xfer_t       q[$];
    xfer_t       cur;
    logic        cur_v, cur_ill;
    int          dp_cnt;
    logic [31:0] last_rd;
    logic [7:0]  mm [WIN];
    int          checks, errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic xfer_t mk_x(input logic [31:0] a, input logic w, input logic [2:0] s,
                                   input logic [31:0] d);
        xfer_t t;
        t.kind = 0; t.addr = a; t.wr = w; t.size = s; t.wdata = d;
        t.sel = 1'b1; t.trans = 2'd2; t.chk = 1'b0; t.cval = 32'd0;
        return t;
    endfunction

    function automatic xfer_t mk_rc(input logic [31:0] a, input logic [31:0] c);
        xfer_t t;
        t = mk_x(a, 1'b0, 3'd2, 32'd0);
        t.chk = 1'b1; t.cval = c;
        return t;
    endfunction

    function automatic xfer_t mk_idle(input logic s, input logic [1:0] tr);
        xfer_t t;
        t = mk_x($urandom, 1'b0, 3'd2, 32'd0);
        t.kind = 1; t.sel = s; t.trans = tr;
        return t;
    endfunction

    function automatic xfer_t mk_stall(input logic [31:0] a);
        xfer_t t;
        t = mk_x(a, 1'b1, 3'd2, 32'd0);
        t.kind = 2;
        return t;
    endfunction

    function automatic logic is_illegal(input logic [31:0] a, input logic [2:0] s);
        longint lo, hi, aa;
        if (s > 3'd2) return 1'b1;
        if ((a % (32'd1 << s)) != 0) return 1'b1;
        aa = longint'(a);
        lo = longint'(BASE_ADDR);
        hi = lo + MEM_BYTES;
        return (aa < lo) || (aa >= hi);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w;
        w = int'(a) & ~3;
        return {mm[w+3], mm[w+2], mm[w+1], mm[w]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int b;
        for (int i = 0; i < (1 << s); i++) begin
            b = int'(a) + i;
            mm[b] = d[8*(b % 4) +: 8];
        end
    endtask

    task automatic drive_misc();
        HBURST    = 3'($urandom);
        HPROT     = 4'($urandom);
        HMASTLOCK = 1'($urandom);
    endtask

    task automatic drive_idle();
        HSEL = 1'b0; HTRANS = 2'd0; HREADY = 1'b1; HADDR = $urandom;
        HWRITE = 1'b0; HSIZE = 3'd0; HWDATA = $urandom;
        drive_misc();
    endtask

    // One bus cycle: check this cycle's response, drive the master side, advance the model.
    task automatic step();
        logic        fin;
        logic [31:0] exp;
        xfer_t       hd;
        @(negedge HCLK);
        if (!cur_v) begin
            fin = 1'b1;
            check("idle_ready", HREADYOUT, 1);
            check("idle_resp", HRESP, 0);
            check("idle_rdata_hold", HRDATA, last_rd);
        end else if (cur_ill) begin
            fin = (dp_cnt == 1);
            check("err_ready", HREADYOUT, fin);
            check("err_resp", HRESP, 1);
            check("err_rdata_hold", HRDATA, last_rd);
        end else begin
            fin = (dp_cnt == EXP_WAITS);
            check("ok_ready", HREADYOUT, fin);
            check("ok_resp", HRESP, 0);
            if (fin && !cur.wr) begin
                exp = model_read(cur.addr);
                check("rd_data", HRDATA, exp);
                if (cur.chk) check("rd_const", HRDATA, cur.cval);
                last_rd = exp;
            end else begin
                check("ok_rdata_hold", HRDATA, last_rd);
            end
        end

        HWDATA = (cur_v && cur.wr) ? cur.wdata : $urandom;
        hd = (q.size() > 0) ? q[0] : mk_idle(1'($urandom), 2'd0);
        drive_misc();
        HADDR = hd.addr; HWRITE = hd.wr; HSIZE = hd.size;
        case (hd.kind)
            0: begin HSEL = 1'b1; HTRANS = 2'($urandom_range(2, 3)); HREADY = fin; end
            1: begin HSEL = hd.sel; HTRANS = hd.trans; HREADY = fin; end
            default: begin HSEL = 1'b1; HTRANS = 2'd2; HREADY = 1'b0; end
        endcase

        if (fin) begin
            if (cur_v && !cur_ill && cur.wr) model_write(cur.addr, cur.size, cur.wdata);
            cur_v = 1'b0;
            if (q.size() > 0) begin
                hd = q.pop_front();
                if (hd.kind == 0) begin
                    cur = hd; cur_v = 1'b1; dp_cnt = 0;
                    cur_ill = is_illegal(hd.addr, hd.size);
                end
            end
        end else begin
            dp_cnt++;
        end
    endtask

    task automatic run_queue();
        while (q.size() > 0 || cur_v) step();
        step();
    endtask

    initial begin
        checks = 0; errors = 0;
        cur_v = 1'b0; cur_ill = 1'b0; dp_cnt = 0; last_rd = 32'd0;
        cur = mk_idle(1'b0, 2'd0);

        // Reset with random bus activity.
        HRESETn = 1'b0;
        drive_idle();
        HSEL = 1'($urandom); HTRANS = 2'($urandom); HREADY = 1'($urandom); HWRITE = 1'($urandom);
        @(posedge HCLK);
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            check("rst_ready", HREADYOUT, 1);
            check("rst_resp", HRESP, 0);
            check("rst_rdata", HRDATA, 0);
            HSEL = 1'($urandom); HTRANS = 2'($urandom); HREADY = 1'($urandom);
            HWRITE = 1'($urandom); HADDR = $urandom; HSIZE = 3'($urandom); HWDATA = $urandom;
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        drive_idle();

        // Initialise the test window so every later read is defined.
        for (int a = 0; a < WIN; a += 4) q.push_back(mk_x(a, 1'b1, 3'd2, $urandom));

        // Back-to-back write/read, byte merge, error cases.
        q.push_back(mk_x(32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF));
        q.push_back(mk_rc(32'h10, 32'hDEAD_BEEF));
        q.push_back(mk_x(32'h13, 1'b1, 3'd0, 32'hAA00_0000));
        q.push_back(mk_rc(32'h10, 32'hAAAD_BEEF));
        q.push_back(mk_x(32'h12, 1'b0, 3'd2, 32'd0));
        q.push_back(mk_idle(1'b0, 2'd0));
        q.push_back(mk_x(32'h1000, 1'b1, 3'd2, 32'h1234_5678));
        q.push_back(mk_x(32'h0, 1'b0, 3'd2, 32'd0));
        q.push_back(mk_x(32'h11, 1'b0, 3'd1, 32'd0));
        q.push_back(mk_x(32'h10, 1'b0, 3'd3, 32'd0));
        q.push_back(mk_rc(32'h10, 32'hAAAD_BEEF));

        // Stalled NONSEQ cycles must not be captured.
        q.push_back(mk_idle(1'b0, 2'd0));
        for (int i = 0; i < 3; i++) q.push_back(mk_stall(32'h28));
        q.push_back(mk_x(32'h24, 1'b1, 3'd2, 32'h5A5A_1234));
        q.push_back(mk_rc(32'h24, 32'h5A5A_1234));
        q.push_back(mk_x(32'h28, 1'b0, 3'd2, 32'd0));
        run_queue();

        // Random traffic.
        for (int i = 0; i < 250; i++) begin
            int r, m;
            logic [2:0]  s;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            if (r < 12) begin
                logic sl;
                sl = 1'($urandom);
                q.push_back(mk_idle(sl, sl ? 2'($urandom_range(0, 1)) : 2'($urandom)));
            end else if (r < 24) begin
                m = $urandom_range(0, 2);
                if (m == 0) begin
                    s = 3'($urandom_range(3, 7)); a = $urandom_range(0, WIN - 1) & ~3;
                end else if (m == 1) begin
                    s = 3'($urandom_range(1, 2));
                    a = (s == 3'd1) ? ($urandom_range(0, WIN - 1) | 1) : ($urandom_range(0, WIN / 4 - 1) * 4 + $urandom_range(1, 3));
                end else begin
                    s = 3'd2; a = 32'h1000 + 4 * $urandom_range(0, 4000);
                end
                q.push_back(mk_x(a, 1'($urandom), s, $urandom));
            end else begin
                s = 3'($urandom_range(0, 2));
                a = $urandom_range(0, WIN - 1) & ~((32'd1 << s) - 1);
                q.push_back(mk_x(a, 1'($urandom), s, $urandom));
            end
        end
        run_queue();

        // Reset during a write's data phase discards the write.
        @(negedge HCLK);
        check("pre_rst_ready", HREADYOUT, 1);
        HSEL = 1'b1; HTRANS = 2'd2; HREADY = 1'b1; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = 3'd2;
        @(negedge HCLK);
        HWDATA = ~model_read(32'h20);
        HRESETn = 1'b0;
        HSEL = 1'b0; HTRANS = 2'd0;
        @(negedge HCLK);
        check("mid_rst_ready", HREADYOUT, 1);
        check("mid_rst_resp", HRESP, 0);
        check("mid_rst_rdata", HRDATA, 0);
        HRESETn = 1'b1;
        drive_idle();
        last_rd = 32'd0;
        cur_v = 1'b0;
        q.push_back(mk_x(32'h20, 1'b0, 3'd2, 32'd0));
        q.push_back(mk_x(32'h10, 1'b0, 3'd2, 32'd0));
        run_queue();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
